// File: rtl/lock_supervisor_pkg.sv
// lock_supervisor_pkg
// Shared definitions for the PLL lock supervisor: FSM state encodings,
// default parameter values and a counter-width helper.
package lock_supervisor_pkg;

  // FSM state encodings (also driven out on the state port)
  localparam logic [1:0] ST_WAIT = 2'b00;
  localparam logic [1:0] ST_STAB = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_LOST = 2'b11;

  // Default parameter values
  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int LOST_HOLD_DEF     = 256;
  localparam int FAST_BIT_DEF      = 20;
  localparam int SLOW_BIT_DEF      = 23;

  localparam int BLINK_W = 24;

  // Width of a counter that must hold 0..n-1; never narrower than 1 bit so
  // that a parameter of 1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronised output (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/lock_supervisor.sv
// lock_supervisor
// Sits between the PLL and user logic. Qualifies the PLL lock flag for
// STABLE_CYCLES consecutive cycles before releasing the downstream reset,
// holds reset for LOST_HOLD cycles after any lock loss, counts losses and
// drives a status LED (off / fast blink / slow blink / on).
// Ports:
//   clk        - PLL output clock, the only clock
//   rst        - synchronous active-high reset
//   pll_locked - raw PLL lock flag, asynchronous to clk
//   sys_rst    - registered active-high reset for downstream logic
//   led        - status LED, active-high
//   state      - current FSM state (WAIT/STAB/RUN/LOST)
//   loss_cnt   - saturating count of RUN->LOST transitions
module lock_supervisor
  import lock_supervisor_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int LOST_HOLD     = LOST_HOLD_DEF,
  parameter int FAST_BIT      = FAST_BIT_DEF,
  parameter int SLOW_BIT      = SLOW_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       sys_rst,
  output logic       led,
  output logic [1:0] state,
  output logic [7:0] loss_cnt
);

  localparam int STAB_W = cnt_width(STABLE_CYCLES);
  localparam int HOLD_W = cnt_width(LOST_HOLD);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOST_HOLD - 1);

  logic lk;

  logic [1:0]         state_q,    state_d;
  logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]         loss_cnt_q, loss_cnt_d;
  logic [BLINK_W-1:0] blink_q,    blink_d;
  logic               sys_rst_q,  sys_rst_d;
  logic               led_q,      led_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    hold_cnt_d = hold_cnt_q;
    loss_cnt_d = loss_cnt_q;
    blink_d    = blink_q + 1'b1;

    case (state_q)
      ST_WAIT: begin
        if (lk) begin
          state_d    = ST_STAB;
          stab_cnt_d = '0;
        end
      end
      ST_STAB: begin
        // Any lk drop, even one cycle, restarts qualification from scratch.
        if (!lk) begin
          state_d = ST_WAIT;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d = ST_RUN;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          state_d    = ST_LOST;
          hold_cnt_d = '0;
          if (loss_cnt_q != 8'hFF) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
          end
        end
      end
      ST_LOST: begin
        // lk is deliberately ignored: the hold time is unconditional.
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Outputs are registered from next-state so they move on the same edge
    // as the state register.
    sys_rst_d = (state_d != ST_RUN);

    case (state_d)
      ST_STAB: led_d = blink_d[FAST_BIT];
      ST_RUN:  led_d = blink_d[SLOW_BIT];
      ST_LOST: led_d = 1'b1;
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT;
      stab_cnt_q <= '0;
      hold_cnt_q <= '0;
      loss_cnt_q <= '0;
      blink_q    <= '0;
      sys_rst_q  <= 1'b1;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      blink_q    <= blink_d;
      sys_rst_q  <= sys_rst_d;
      led_q      <= led_d;
    end
  end

  assign state    = state_q;
  assign loss_cnt = loss_cnt_q;
  assign sys_rst  = sys_rst_q;
  assign led      = led_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// tb_lock_supervisor
// Directed bench for lock_supervisor with small parameters.
module tb_lock_supervisor;

  localparam int SC = 8;
  localparam int LH = 4;
  localparam int FB = 2;
  localparam int SB = 4;

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] S = 2'b01;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] L = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sys_rst;
  logic       led;
  logic [1:0] state;
  logic [7:0] loss_cnt;

  int total = 0;
  int bad = 0;
  logic [23:0] bcnt = '0;

  lock_supervisor #(
    .STABLE_CYCLES (SC),
    .LOST_HOLD     (LH),
    .FAST_BIT      (FB),
    .SLOW_BIT      (SB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .sys_rst    (sys_rst),
    .led        (led),
    .state      (state),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  // Expected LED for a given state and the blink count after the edge.
  function automatic logic exp_led(input logic [1:0] st, input logic [23:0] b);
    case (st)
      S:       return b[FB];
      R:       return b[SB];
      L:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Advance n edges; sample 1 ns after each edge. bcnt mirrors the
  // free-running counter: cleared by a reset edge, otherwise +1.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) bcnt = '0;
      else     bcnt = bcnt + 24'd1;
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pll_locked = 1'b0;
    do_reset();
    total++; if (state !== W)        begin bad++; $display("FAIL rst_state: got %0d want %0d", state, W); end
    total++; if (sys_rst !== 1'b1)   begin bad++; $display("FAIL rst_sys_rst: got %0b want 1", sys_rst); end
    total++; if (led !== 1'b0)       begin bad++; $display("FAIL rst_led: got %0b want 0", led); end
    total++; if (loss_cnt !== 8'd0)  begin bad++; $display("FAIL rst_loss_cnt: got %0d want 0", loss_cnt); end
    // Unlocked: WAIT with LED dark.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      total++; if (state !== W)  begin bad++; $display("FAIL wait_state c%0d: got %0d want %0d", i, state, W); end
      total++; if (led !== 1'b0) begin bad++; $display("FAIL wait_led c%0d: got %0b want 0", i, led); end
    end
  endtask

  task automatic test_acquire();
    logic [1:0] es;
    logic prev_led;
    int toggles;
    do_reset();
    pll_locked = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick(1);
      es = (e < 3) ? W : (e < 11) ? S : R;
      total++; if (state !== es) begin bad++; $display("FAIL acq_state e%0d: got %0d want %0d", e, state, es); end
      total++; if (sys_rst !== (e < 11)) begin bad++; $display("FAIL acq_sys_rst e%0d: got %0b want %0b", e, sys_rst, (e < 11)); end
      total++; if (led !== exp_led(es, bcnt)) begin bad++; $display("FAIL acq_led e%0d: got %0b want %0b", e, led, exp_led(es, bcnt)); end
    end
    prev_led = led;
    toggles = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (led !== prev_led) toggles++;
      prev_led = led;
      total++; if (state !== R) begin bad++; $display("FAIL run_state c%0d: got %0d want %0d", i, state, R); end
      total++; if (led !== bcnt[SB]) begin bad++; $display("FAIL run_led c%0d: got %0b want %0b", i, led, bcnt[SB]); end
    end
    total++; if (toggles != 4) begin bad++; $display("FAIL run_led_toggles: got %0d want 4", toggles); end
    total++; if (loss_cnt !== 8'd0) begin bad++; $display("FAIL acq_loss_cnt: got %0d want 0", loss_cnt); end
  endtask

  task automatic test_glitch();
    logic [1:0] es;
    do_reset();
    pll_locked = 1'b1;
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    // lk is low while stab_cnt==5 (edge 9); restart from WAIT.
    for (int e = 8; e <= 18; e++) begin
      tick(1);
      es = (e == 9) ? W : (e < 18) ? S : R;
      total++; if (state !== es) begin bad++; $display("FAIL glitch_state e%0d: got %0d want %0d", e, state, es); end
      total++; if (sys_rst !== (e < 18)) begin bad++; $display("FAIL glitch_sys_rst e%0d: got %0b want %0b", e, sys_rst, (e < 18)); end
    end
  endtask

  task automatic test_loss();
    logic [1:0] es;
    logic [7:0] el;
    // Enters in RUN with no losses.
    pll_locked = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (k == 3) pll_locked = 1'b1;
      es = (k <= 2) ? R : (k <= 6) ? L : (k == 7) ? W : (k <= 15) ? S : R;
      el = (k >= 3) ? 8'd1 : 8'd0;
      total++; if (state !== es) begin bad++; $display("FAIL loss_state k%0d: got %0d want %0d", k, state, es); end
      total++; if (sys_rst !== (es != R)) begin bad++; $display("FAIL loss_sys_rst k%0d: got %0b want %0b", k, sys_rst, (es != R)); end
      total++; if (led !== exp_led(es, bcnt)) begin bad++; $display("FAIL loss_led k%0d: got %0b want %0b", k, led, exp_led(es, bcnt)); end
      total++; if (loss_cnt !== el) begin bad++; $display("FAIL loss_cnt k%0d: got %0d want %0d", k, loss_cnt, el); end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] el;
    do_reset();
    pll_locked = 1'b1;
    tick(11);
    for (int i = 1; i <= 256; i++) begin
      pll_locked = 1'b0;
      tick(3);
      el = (i < 255) ? 8'(i) : 8'd255;
      total++; if (state !== L) begin bad++; $display("FAIL sat_state_lost i%0d: got %0d want %0d", i, state, L); end
      total++; if (loss_cnt !== el) begin bad++; $display("FAIL sat_loss_cnt i%0d: got %0d want %0d", i, loss_cnt, el); end
      pll_locked = 1'b1;
      tick(13);
      total++; if (state !== R) begin bad++; $display("FAIL sat_state_run i%0d: got %0d want %0d", i, state, R); end
    end
  endtask

  task automatic test_rst_mid();
    // Enters in RUN with loss_cnt saturated.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total++; if (state !== W)       begin bad++; $display("FAIL mid_state: got %0d want %0d", state, W); end
    total++; if (sys_rst !== 1'b1)  begin bad++; $display("FAIL mid_sys_rst: got %0b want 1", sys_rst); end
    total++; if (loss_cnt !== 8'd0) begin bad++; $display("FAIL mid_loss_cnt: got %0d want 0", loss_cnt); end
    total++; if (led !== 1'b0)      begin bad++; $display("FAIL mid_led: got %0b want 0", led); end
    tick(2);
    total++; if (state !== W) begin bad++; $display("FAIL mid_req_wait: got %0d want %0d", state, W); end
    tick(1);
    total++; if (state !== S) begin bad++; $display("FAIL mid_req_stab: got %0d want %0d", state, S); end
    tick(8);
    total++; if (state !== R) begin bad++; $display("FAIL mid_req_run: got %0d want %0d", state, R); end
    total++; if (sys_rst !== 1'b0) begin bad++; $display("FAIL mid_req_sys_rst: got %0b want 0", sys_rst); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_glitch();
    test_loss();
    test_saturation();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lock_supervisor.md
LOCK_SUPERVISOR -- requirements
Module: lock_supervisor

Interface
REQ-001 Parameter STABLE_CYCLES, default 1024: number of consecutive synchronised-locked cycles required before reset release (minimum 2).
REQ-002 Parameter LOST_HOLD, default 256: number of cycles reset is held after a lock loss, regardless of lock state (minimum 1).
REQ-003 Parameter FAST_BIT, default 20: blink-counter bit used for the fast LED blink.
REQ-004 Parameter SLOW_BIT, default 23: blink-counter bit used for the slow LED blink; FAST_BIT < SLOW_BIT <= 23.
REQ-005 Port clk, input, 1: PLL output clock (CLK0 of the PLL); the only clock in the block.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port pll_locked, input, 1: PLL lock flag (USR_PLL_LOCKED); asynchronous to clk.
REQ-008 Port sys_rst, output, 1: registered active-high synchronous reset for downstream logic.
REQ-009 Port led, output, 1: status LED drive for the CCEVB/OLIMEX LEDs, active-high.
REQ-010 Port state, output, 2: current FSM state (WAIT=00, STAB=01, RUN=10, LOST=11).
REQ-011 Port loss_cnt, output, 8: number of RUN->LOST transitions, saturating.

Function
REQ-012 pll_locked SHALL pass through a 2-flop synchroniser; its output, lk, is the only lock signal the FSM uses.
REQ-013 WAIT: sys_rst=1; when lk=1, go to STAB and clear stab_cnt.
REQ-014 STAB: sys_rst=1.
- lk=0: return to WAIT.
- lk=1 and stab_cnt==STABLE_CYCLES-1: go to RUN.
- Otherwise: increment stab_cnt.
REQ-015 RUN: sys_rst=0; when lk=0, go to LOST, increment loss_cnt (saturating at 255) and clear hold_cnt.
REQ-016 LOST: sys_rst=1; ignore lk; increment hold_cnt each cycle; when hold_cnt==LOST_HOLD-1, go to WAIT.
REQ-017 sys_rst SHALL be registered from the next-state value, so it changes on the same edge as the state register.
REQ-018 Latency: with pll_locked held high from edge 1, sys_rst SHALL deassert at edge 3+STABLE_CYCLES.
REQ-019 A single-cycle lk=0 glitch in STAB SHALL restart qualification from WAIT.
REQ-020 A free-running 24-bit blink counter SHALL increment every cycle and wrap from 0xFFFFFF to 0.
REQ-021 led per state:
- WAIT: 0.
- STAB: blink_cnt[FAST_BIT].
- RUN: blink_cnt[SLOW_BIT].
- LOST: 1.
REQ-022 At loss_cnt=255, a further loss SHALL leave it at 255 while the FSM still enters LOST.
REQ-023 stab_cnt and hold_cnt SHALL each be sized to ceil(log2) of their parameter; no counter wraps within a state.

Reset
REQ-024 While rst=1 at an edge, the block SHALL load:
- state=WAIT, sys_rst=1, led=0, loss_cnt=0;
- stab_cnt=0, hold_cnt=0, blink counter=0;
- both synchroniser flops=0.
REQ-025 rst asserted mid-operation (any state) SHALL take effect on that edge; qualification restarts from WAIT after rst deasserts.

Structure
REQ-026 State encodings and the default parameter values SHALL live in the shared package lock_supervisor_pkg.
REQ-027 The synchroniser SHALL be a separate sub-module, sync_2ff (1-bit, synchronous reset), reusable for other asynchronous inputs.
REQ-028 The block SHALL be instantiated between the PLL and the user logic, replacing direct use of locked for LED gating.

Verification (STABLE_CYCLES=8, LOST_HOLD=4, FAST_BIT=2, SLOW_BIT=4)
REQ-029 rst for 3 edges, then pll_locked=1 from edge 1 -> state=STAB at edge 3, RUN at edge 11, sys_rst falls at edge 11.
REQ-030 In STAB, pll_locked low for 1 cycle at count 5 -> state returns to WAIT, sys_rst stays 1; RUN is reached only 8 STAB cycles after lk returns.
REQ-031 In RUN, pll_locked=0 -> LOST 2 edges later, sys_rst=1, loss_cnt=1, led=1; pll_locked back high immediately -> WAIT after 4 LOST cycles, then RUN after 8 more STAB cycles.
REQ-032 Force 256 lock losses -> loss_cnt=255 and unchanged after the 256th; state still visits LOST.
REQ-033 Assert rst for 1 cycle while in RUN -> next edge: state=WAIT, sys_rst=1, loss_cnt=0, led=0.
REQ-034 Run 64 cycles in RUN -> led toggles every 16 cycles; in STAB, led toggles every 4 cycles; in WAIT, led stays 0.
